// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA HSync/VSync receiver with timing reconstruction and checking
module vga_sync_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       HSync,
  input  logic       VSync,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       locked,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       sync_err,
  output logic [7:0] err_count
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HSTART = H_ACTIVE + H_FP;
  localparam int VSTART = V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST    = 10'(HTOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(VTOTAL - 1);
  localparam logic [9:0] H_SYNC_LO = 10'(HSTART);
  localparam logic [9:0] H_SYNC_HI = 10'(HSTART + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(VSTART);
  localparam logic [9:0] V_SYNC_HI = 10'(VSTART + V_SYNC);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_TIMEOUT = 10'(VTOTAL);

  typedef enum logic [1:0] {
    S_HUNT,
    S_H_MEAS,
    S_V_WAIT,
    S_LOCKED
  } state_t;

  state_t     state, state_n;
  logic       hs_q, vs_q, hs_prev, vs_prev;
  logic       line_ok, line_ok_n;
  logic [9:0] row_n, col_n;
  logic       locked_n, pixel_valid_n, frame_start_n, sync_err_n;

  logic       hs_fall, vs_fall;
  logic       row_wrap;
  logic [9:0] row_inc, col_inc, col_adv;
  logic       hs_exp_low, vs_exp_low;
  logic       hs_bad, vs_bad;

  // Everything below describes the sample in hs_q/vs_q, whose index is row_inc/col_adv.
  assign hs_fall    = hs_prev & ~hs_q;
  assign vs_fall    = vs_prev & ~vs_q;
  assign row_wrap   = (row == H_LAST);
  assign row_inc    = row_wrap ? 10'd0 : row + 10'd1;
  assign col_inc    = (col == V_LAST) ? 10'd0 : col + 10'd1;
  assign col_adv    = row_wrap ? col_inc : col;
  assign hs_exp_low = (row_inc >= H_SYNC_LO) && (row_inc < H_SYNC_HI);
  assign vs_exp_low = (col_adv >= V_SYNC_LO) && (col_adv < V_SYNC_HI);
  assign hs_bad     = (hs_q == hs_exp_low);
  assign vs_bad     = (vs_q == vs_exp_low);

  always_comb begin
    state_n       = state;
    row_n         = row;
    col_n         = col;
    line_ok_n     = line_ok;
    locked_n      = 1'b0;
    pixel_valid_n = 1'b0;
    frame_start_n = 1'b0;
    sync_err_n    = 1'b0;
    case (state)
      S_HUNT: begin
        if (hs_fall) begin
          row_n     = H_SYNC_LO;
          line_ok_n = 1'b0;
          state_n   = S_H_MEAS;
        end
      end
      S_H_MEAS: begin
        if (hs_bad) begin
          sync_err_n = 1'b1;
          state_n    = S_HUNT;
        end else begin
          row_n = row_inc;
          if (row_wrap) begin
            if (line_ok) begin
              col_n   = 10'd0;
              state_n = S_V_WAIT;
            end else begin
              line_ok_n = 1'b1;
            end
          end
        end
      end
      S_V_WAIT: begin
        // col here counts lines since entry, so it may run past VTOTAL-1 to detect timeout
        if (hs_bad || (vs_fall && !row_wrap)) begin
          sync_err_n = 1'b1;
          state_n    = S_HUNT;
        end else if (vs_fall) begin
          row_n    = row_inc;
          col_n    = V_SYNC_LO;
          locked_n = 1'b1;
          state_n  = S_LOCKED;
        end else if (row_wrap && (col == V_TIMEOUT)) begin
          sync_err_n = 1'b1;
          state_n    = S_HUNT;
        end else begin
          row_n = row_inc;
          if (row_wrap) begin
            col_n = col + 10'd1;
          end
        end
      end
      S_LOCKED: begin
        if (hs_bad || vs_bad) begin
          sync_err_n = 1'b1;
          state_n    = S_HUNT;
        end else begin
          row_n         = row_inc;
          col_n         = col_adv;
          locked_n      = 1'b1;
          pixel_valid_n = (row_inc < H_ACT) && (col_adv < V_ACT);
          frame_start_n = (row_inc == 10'd0) && (col_adv == 10'd0);
        end
      end
      default: begin
        state_n = S_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_HUNT;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      line_ok     <= 1'b0;
      row         <= 10'd0;
      col         <= 10'd0;
      locked      <= 1'b0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_n;
      hs_q        <= HSync;
      vs_q        <= VSync;
      hs_prev     <= hs_q;
      vs_prev     <= vs_q;
      line_ok     <= line_ok_n;
      row         <= row_n;
      col         <= col_n;
      locked      <= locked_n;
      pixel_valid <= pixel_valid_n;
      frame_start <= frame_start_n;
      sync_err    <= sync_err_n;
      if (sync_err_n && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
